// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_pkg
//  Purpose  : Opcode encodings, FSM state encodings and overflow helper shared
//             by the execute-stage ALU and its bench.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'h0,
        ALU_OP_SUB  = 4'h1,
        ALU_OP_AND  = 4'h2,
        ALU_OP_OR   = 4'h3,
        ALU_OP_XOR  = 4'h4,
        ALU_OP_NOR  = 4'h5,
        ALU_OP_SLL  = 4'h6,
        ALU_OP_SRL  = 4'h7,
        ALU_OP_SRA  = 4'h8,
        ALU_OP_SLT  = 4'h9,
        ALU_OP_SLTU = 4'hA,
        ALU_OP_MOV  = 4'hB,
        ALU_OP_MUL  = 4'hD
    } alu_op_e;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Signed overflow from operand/result sign bits; SUB overflows when the
    // operand signs differ and the result sign departs from the minuend.
    function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        if (is_sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        else
            return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_if
//  Purpose  : Valid/ready request and result channels of the execute-stage ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zero;
    logic             out_ovf;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_ovf, out_err, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_ovf, out_err, out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_iter
//  Purpose  : Radix-2 shift-add multiplier, one multiplier bit per cycle,
//             producing the low WIDTH bits of a*b.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_start,
    input  wire [WIDTH-1:0]  i_a,
    input  wire [WIDTH-1:0]  i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;

    // Bit 0 is folded into the start cycle, so r_cnt names the bit being added.
    // o_done marks the final add; the product is settled the cycle after.
    assign o_done    = r_run && (r_cnt == c_LAST);
    assign o_product = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= c_ONE;
            r_mcand  <= i_a << 1;
            r_mplier <= i_b >> 1;
            r_acc    <= i_b[0] ? i_a : '0;
        end else if (r_run) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_ONE;
            if (o_done)
                r_run <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Registered valid/ready execute-stage ALU with zero/overflow/error
//             flags. Define ALU_MUL_EN to add the iterative multiplier (0xD).
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  wire        clk,
    input  wire        rst,
    alu_pipe_if.slave  bus
);
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
    logic [TAG_W-1:0] r_tag;

    logic               w_idle;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_wr;
    logic [WIDTH-1:0]   w_mul_prod;
    logic [TAG_W-1:0]   w_mul_tag;
    logic [SHAMT_W-1:0] w_sa;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_err;

    assign w_in_ready = w_idle && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_sa       = bus.in_a[SHAMT_W-1:0];
    assign w_sum      = bus.in_a + bus.in_b;
    assign w_diff     = bus.in_a - bus.in_b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (bus.in_op)
            ALU_OP_ADD: begin
                w_res = w_sum;
                w_ovf = signed_ovf(1'b0, bus.in_a[WIDTH-1], bus.in_b[WIDTH-1], w_sum[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                w_res = w_diff;
                w_ovf = signed_ovf(1'b1, bus.in_a[WIDTH-1], bus.in_b[WIDTH-1], w_diff[WIDTH-1]);
            end
            ALU_OP_AND:  w_res = bus.in_a & bus.in_b;
            ALU_OP_OR:   w_res = bus.in_a | bus.in_b;
            ALU_OP_XOR:  w_res = bus.in_a ^ bus.in_b;
            ALU_OP_NOR:  w_res = ~(bus.in_a | bus.in_b);
            ALU_OP_SLL:  w_res = bus.in_b << w_sa;
            ALU_OP_SRL:  w_res = bus.in_b >> w_sa;
            ALU_OP_SRA:  w_res = $signed(bus.in_b) >>> w_sa;
            ALU_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            ALU_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
            ALU_OP_MOV:  w_res = bus.in_a;
            default:     w_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [1:0]       r_state;
    logic [TAG_W-1:0] r_mul_tag;
    logic             w_mul_start;
    logic             w_mul_done;

    assign w_is_mul    = (bus.in_op == ALU_OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_mul_wr    = (r_state == c_ST_DONE);
    assign w_mul_tag   = r_mul_tag;
    assign bus.busy    = !w_idle;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (bus.in_a),
        .i_b       (bus.in_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_mul_tag <= '0;
        end else begin
            if (w_mul_start)
                r_mul_tag <= bus.in_tag;
            case (r_state)
                c_ST_IDLE: if (w_mul_start) r_state <= c_ST_MUL;
                c_ST_MUL:  if (w_mul_done)  r_state <= c_ST_DONE;
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_idle     = 1'b1;
    assign w_mul_wr   = 1'b0;
    assign w_mul_prod = '0;
    assign w_mul_tag  = '0;
    assign bus.busy   = 1'b0;
`endif

    // A new result may overwrite the register in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_tag       <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_err       <= w_err;
            r_tag       <= bus.in_tag;
        end else if (w_mul_wr) begin
            r_out_valid <= 1'b1;
            r_res       <= w_mul_prod;
            r_zero      <= (w_mul_prod == '0);
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_tag       <= w_mul_tag;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_res;
    assign bus.out_zero  = r_zero;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_err   = r_err;
    assign bus.out_tag   = r_tag;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed self-checking bench for alu_pipe (honours ALU_MUL_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [16];

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_valid;
        vecs[0]  = '{ALU_OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{ALU_OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{ALU_OP_SRA,  32'h00000004, 32'h80000010, 32'hF8000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{ALU_OP_SRL,  32'h00000004, 32'h80000010, 32'h08000001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{ALU_OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ALU_OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{ALU_OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{ALU_OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{ALU_OP_AND,  32'hF0F0FF00, 32'h0FF00FF0, 32'h00F00F00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{ALU_OP_OR,   32'hF0F0FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{ALU_OP_XOR,  32'hF0F0FF00, 32'h0FF00FF0, 32'hFF00F0F0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{ALU_OP_SLL,  32'h00000024, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{ALU_OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'hF,        32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{4'hE,        32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{ALU_OP_MOV,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_op     = 4'h0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        tick();
        tick();
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset out_res",   bus.out_res,   32'h0);
        check("reset out_zero",  bus.out_zero,  1'b0);
        check("reset out_ovf",   bus.out_ovf,   1'b0);
        check("reset out_err",   bus.out_err,   1'b0);
        check("reset out_tag",   bus.out_tag,   5'd0);
        check("reset busy",      bus.busy,      1'b0);
        rst = 1'b0;
        tick();
        check("reset in_ready", bus.in_ready, 1'b1);

        // Vectors issued back-to-back: one result per cycle, tags in order.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
            #1;
            check($sformatf("b2b[%0d] in_ready", i), bus.in_ready, 1'b1);
            tick();
            check($sformatf("b2b[%0d] out_valid", i), bus.out_valid, 1'b1);
            check($sformatf("b2b[%0d] out_res", i),   bus.out_res,   vecs[i].res);
            check($sformatf("b2b[%0d] out_ovf", i),   bus.out_ovf,   vecs[i].ovf);
            check($sformatf("b2b[%0d] out_zero", i),  bus.out_zero,  vecs[i].zero);
            check($sformatf("b2b[%0d] out_err", i),   bus.out_err,   vecs[i].err);
            check($sformatf("b2b[%0d] out_tag", i),   bus.out_tag,   5'(i));
        end

        // Consumer stall: held output, no acceptance.
        bus.out_ready = 1'b0;
        drive(ALU_OP_MOV, 32'h0000CAFE, 32'h0, 5'd20);
        #1;
        check("stall in_ready", bus.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall[%0d] out_valid", k), bus.out_valid, 1'b1);
            check($sformatf("stall[%0d] out_res", k),   bus.out_res,   32'h12345678);
            check($sformatf("stall[%0d] out_tag", k),   bus.out_tag,   5'd15);
            check($sformatf("stall[%0d] in_ready", k),  bus.in_ready,  1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall in_ready", bus.in_ready, 1'b1);
        tick();
        check("unstall out_res", bus.out_res, 32'h0000CAFE);
        check("unstall out_tag", bus.out_tag, 5'd20);
        bus.in_valid = 1'b0;
        tick();
        check("drain out_valid", bus.out_valid, 1'b0);

`ifndef ALU_MUL_EN
        drive(4'hD, 32'h3, 32'h4, 5'd9);
        tick();
        bus.in_valid = 1'b0;
        check("op D out_valid", bus.out_valid, 1'b1);
        check("op D out_err",   bus.out_err,   1'b1);
        check("op D out_res",   bus.out_res,   32'h0);
        check("op D out_tag",   bus.out_tag,   5'd9);
        check("op D busy",      bus.busy,      1'b0);
        tick();
`endif

        // Reset while a result is held by a stalled consumer.
        drive(ALU_OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd7);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check("held out_valid", bus.out_valid, 1'b1);
        check("held out_ovf",   bus.out_ovf,   1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst held out_valid", bus.out_valid, 1'b0);
        check("rst held out_res",   bus.out_res,   32'h0);
        check("rst held out_ovf",   bus.out_ovf,   1'b0);
        check("rst held out_tag",   bus.out_tag,   5'd0);
        tick();
        check("rst held in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;

`ifdef ALU_MUL_EN
        drive(ALU_OP_MUL, 32'h00010000, 32'h00010003, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            check($sformatf("mul wait[%0d] out_valid", k), bus.out_valid, 1'b0);
            check($sformatf("mul wait[%0d] in_ready", k),  bus.in_ready,  1'b0);
            check($sformatf("mul wait[%0d] busy", k),      bus.busy,      1'b1);
            tick();
        end
        tick();
        check("mul out_valid", bus.out_valid, 1'b1);
        check("mul out_res",   bus.out_res,   32'h00030000);
        check("mul out_tag",   bus.out_tag,   5'd3);
        check("mul out_ovf",   bus.out_ovf,   1'b0);
        check("mul out_err",   bus.out_err,   1'b0);
        check("mul busy",      bus.busy,      1'b0);
        check("mul in_ready",  bus.in_ready,  1'b1);

        drive(ALU_OP_MUL, 32'h7, 32'h9, 5'd4);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mul abort in_ready", bus.in_ready, 1'b1);
        check("mul abort busy",     bus.busy,     1'b0);
        saw_valid = 1'b0;
        repeat (2 * WIDTH) begin
            tick();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("mul abort no result", saw_valid, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
